// File: rtl/aes_key_pkg.sv
// Shared AES key-length encodings, column width and streamer state type.
package aes_key_pkg;

  localparam int unsigned WORD_BITS = 32;

  localparam logic [1:0] KEY_LEN_128     = 2'b00;
  localparam logic [1:0] KEY_LEN_192     = 2'b01;
  localparam logic [1:0] KEY_LEN_256     = 2'b10;
  localparam logic [1:0] KEY_LEN_ILLEGAL = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Number of 32-bit columns for a key length; the illegal code maps to 4 but is never captured.
  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    logic [3:0] nk;
    nk = 4'd4;
    case (key_len)
      KEY_LEN_128: nk = 4'd4;
      KEY_LEN_192: nk = 4'd6;
      KEY_LEN_256: nk = 4'd8;
      default:     nk = 4'd4;
    endcase
    return nk;
  endfunction

endpackage

// File: rtl/key_word_mux.sv
// Combinational column selector: picks column idx_i of an MSB-aligned key.
module key_word_mux #(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned WORD_BITS    = 32,
  parameter int unsigned IDX_BITS     = 3
) (
  input  logic [MAX_KEY_BITS-1:0] key_i,
  input  logic [IDX_BITS-1:0]     idx_i,
  output logic [WORD_BITS-1:0]    word_o
);

  localparam int unsigned NUM_WORDS = MAX_KEY_BITS / WORD_BITS;

  // Column i lives at key_i[MAX_KEY_BITS-1-WORD_BITS*i -: WORD_BITS].
  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (idx_i == IDX_BITS'(i)) begin
        word_o = key_i[MAX_KEY_BITS-1-WORD_BITS*i -: WORD_BITS];
      end
    end
  end

endmodule

// File: rtl/key_word_streamer.sv
// Registers an AES-128/192/256 key and streams it out as Nk 32-bit columns.
module key_word_streamer #(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned WORD_BITS    = 32,
  parameter int unsigned IDX_BITS     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  input  logic [1:0]              key_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_BITS-1:0]    out_word,
  output logic [IDX_BITS-1:0]     out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_len
);

  import aes_key_pkg::*;

  localparam int unsigned NK_BITS = IDX_BITS + 1;

  state_e                  state_q;
  logic [MAX_KEY_BITS-1:0] key_q;
  logic [NK_BITS-1:0]      nk_q;
  logic [IDX_BITS-1:0]     cnt_q;
  logic [WORD_BITS-1:0]    out_word_q;
  logic [IDX_BITS-1:0]     out_index_q;
  logic                    out_last_q;
  logic                    err_len_q;

  logic [IDX_BITS-1:0]     cnt_inc;
  logic [WORD_BITS-1:0]    next_word;
  logic                    load;
  logic                    load_legal;

  // A new key may enter when idle, or exactly when the last column is being taken.
  assign in_ready   = !flush && ((state_q == IDLE) ||
                                 ((state_q == STREAM) && out_last_q && out_ready));
  assign load       = in_valid && in_ready;
  assign load_legal = (key_len != KEY_LEN_ILLEGAL);
  assign cnt_inc    = cnt_q + IDX_BITS'(1);

  // Column that follows the one currently presented.
  key_word_mux #(
    .MAX_KEY_BITS(MAX_KEY_BITS),
    .WORD_BITS   (WORD_BITS),
    .IDX_BITS    (IDX_BITS)
  ) u_mux (
    .key_i (key_q),
    .idx_i (cnt_inc),
    .word_o(next_word)
  );

  // Load / stream / flush state machine with registered column outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      nk_q        <= '0;
      cnt_q       <= '0;
      out_word_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      err_len_q <= 1'b0;
      if (flush) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        out_index_q <= '0;
        out_last_q  <= 1'b0;
      end else if (load && load_legal) begin
        state_q     <= STREAM;
        key_q       <= key_in;
        nk_q        <= NK_BITS'(nk_of(key_len));
        cnt_q       <= '0;
        out_word_q  <= key_in[MAX_KEY_BITS-1 -: WORD_BITS];
        out_index_q <= '0;
        out_last_q  <= 1'b0;
      end else if (load) begin
        // Illegal length: consume the load, capture nothing, flag it.
        state_q    <= IDLE;
        err_len_q  <= 1'b1;
        cnt_q      <= '0;
        out_last_q <= 1'b0;
      end else if ((state_q == STREAM) && out_ready) begin
        if (out_last_q) begin
          state_q    <= IDLE;
          out_last_q <= 1'b0;
        end else begin
          cnt_q       <= cnt_inc;
          out_word_q  <= next_word;
          out_index_q <= cnt_inc;
          out_last_q  <= (NK_BITS'(cnt_inc) == (nk_q - NK_BITS'(1)));
        end
      end
    end
  end

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_word  = out_word_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_key_word_streamer.sv
// Randomized + directed bench for key_word_streamer with a queue-based scoreboard.
module tb_key_word_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic [2:0]   out_index;
  logic         out_last;
  logic         busy;
  logic         err_len;

  typedef struct packed {
    logic [31:0] w;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  logic [34:0] seen_q[$];
  bit          err_exp  = 1'b0;
  bit          zero_exp = 1'b1;
  int          checks   = 0;
  int          failures = 0;

  key_word_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_in   (key_in),
    .key_len  (key_len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word (out_word),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nk_model(input logic [1:0] len);
    if (len == 2'b00) return 4;
    if (len == 2'b01) return 6;
    return 8;
  endfunction

  function automatic logic [31:0] col(input logic [255:0] k, input int i);
    logic [255:0] t;
    t = k >> (32 * (7 - i));
    return t[31:0];
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees a settled cycle.
  always @(negedge clk) begin
    bit   exp_ready;
    bit   exp_valid;
    exp_t e;
    exp_valid = (sb_q.size() > 0);
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(exp_valid));
    chk("err_len", 32'(err_len), 32'(err_exp));
    if (zero_exp) begin
      chk("rst_word", out_word, 32'h0);
      chk("rst_index", 32'(out_index), 32'h0);
      chk("rst_last", 32'(out_last), 32'h0);
    end
    exp_ready = !flush && (sb_q.size() == 0 || (sb_q.size() == 1 && out_ready));
    if (!rst) chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (exp_valid && out_valid) begin
      chk("out_word", out_word, sb_q[0].w);
      chk("out_index", 32'(out_index), 32'(sb_q[0].idx));
      chk("out_last", 32'(out_last), 32'(sb_q[0].last));
    end
    // Advance the reference model across the coming edge.
    if (rst) begin
      sb_q.delete();
      err_exp  = 1'b0;
      zero_exp = 1'b1;
    end else begin
      zero_exp = 1'b0;
      err_exp  = 1'b0;
      if (flush) begin
        sb_q.delete();
      end else begin
        if (sb_q.size() > 0 && out_ready) begin
          if (out_valid) seen_q.push_back({out_index, out_word});
          void'(sb_q.pop_front());
        end
        if (in_valid && exp_ready) begin
          if (key_len == 2'b11) begin
            err_exp = 1'b1;
          end else begin
            for (int i = 0; i < nk_model(key_len); i++) begin
              e.w    = col(key_in, i);
              e.idx  = 3'(i);
              e.last = (i == nk_model(key_len) - 1);
              sb_q.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      step();
      n++;
    end
    chk(name, 32'(busy), 32'h0);
  endtask

  task automatic wait_index(input string name, input logic [2:0] idx, input int max_cycles);
    int n = 0;
    while (!(out_valid && out_index == idx) && n < max_cycles) begin
      step();
      n++;
    end
    chk(name, 32'(out_valid && out_index == idx), 32'h1);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  logic [31:0] fips128 [4] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
  logic [31:0] fips256 [8] = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                               32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};

  initial begin
    bit acc;
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; key_in = '0; key_len = 2'b00; out_ready = 1'b1;
    step(); step();
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    step();

    // FIPS-197 128-bit key, no backpressure.
    seen_q.delete();
    in_valid = 1'b1; key_len = 2'b00;
    key_in = {fips128[0], fips128[1], fips128[2], fips128[3], 128'h0};
    step();
    in_valid = 1'b0;
    chk("k128_first_valid", 32'(out_valid), 32'h1);
    chk("k128_first_index", 32'(out_index), 32'h0);
    wait_idle("k128_timeout", 20);
    step();
    chk("k128_count", 32'(seen_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
      chk("k128_word", seen_q[i][31:0], fips128[i]);
      chk("k128_idx", 32'(seen_q[i][34:32]), 32'(i));
    end

    // FIPS-197 256-bit key with alternating backpressure.
    seen_q.delete();
    in_valid = 1'b1; key_len = 2'b10;
    key_in = {fips256[0], fips256[1], fips256[2], fips256[3],
              fips256[4], fips256[5], fips256[6], fips256[7]};
    step();
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      out_ready = ~out_ready;
      step();
      n++;
    end
    chk("k256_timeout", 32'(busy), 32'h0);
    out_ready = 1'b1;
    step();
    chk("k256_count", 32'(seen_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen_q.size(); i++) begin
      chk("k256_word", seen_q[i][31:0], fips256[i]);
    end

    // Back-to-back: 192-bit key, then a 128-bit key held until accepted.
    seen_q.delete();
    in_valid = 1'b1; key_len = 2'b01; key_in = rand_key();
    step();
    key_len = 2'b00; key_in = rand_key();
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_accept", 32'(acc), 32'h1);
    chk("b2b_second_idx0", 32'(out_valid && out_index == 3'd0), 32'h1);
    wait_idle("b2b_timeout", 20);
    step();
    chk("b2b_count", 32'(seen_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < seen_q.size(); i++) begin
      chk("b2b_idx", 32'(seen_q[i][34:32]), (i < 6) ? 32'(i) : 32'(i - 6));
    end

    // Illegal key length, then a legal key.
    in_valid = 1'b1; key_len = 2'b11; key_in = '1;
    step();
    in_valid = 1'b0;
    chk("illegal_err", 32'(err_len), 32'h1);
    chk("illegal_valid", 32'(out_valid), 32'h0);
    step();
    chk("illegal_err_clear", 32'(err_len), 32'h0);
    in_valid = 1'b1; key_len = 2'b01; key_in = rand_key();
    step();
    in_valid = 1'b0;
    wait_idle("after_illegal_timeout", 20);

    // Flush at index 2 with a competing load.
    in_valid = 1'b1; key_len = 2'b10; key_in = rand_key();
    step();
    in_valid = 1'b0;
    wait_index("flush_reach_idx2", 3'd2, 20);
    flush = 1'b1; in_valid = 1'b1; key_in = rand_key(); key_len = 2'b00;
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_busy", 32'(busy), 32'h0);
    in_valid = 1'b1; key_len = 2'b00; key_in = rand_key();
    step();
    in_valid = 1'b0;
    chk("flush_restart_idx", 32'(out_valid && out_index == 3'd0), 32'h1);
    wait_idle("flush_restart_timeout", 20);

    // Reset mid-stream, held three cycles.
    in_valid = 1'b1; key_len = 2'b10; key_in = rand_key();
    step();
    in_valid = 1'b0;
    wait_index("rst_reach_idx5", 3'd5, 20);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_mid_valid", 32'(out_valid), 32'h0);
      chk("rst_mid_word", out_word, 32'h0);
      chk("rst_mid_ready", 32'(in_ready), 32'h1);
    end
    rst = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) == 0);
      key_len   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      key_in    = rand_key();
      flush     = ($urandom_range(0, 32) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("drain_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
